// File: rtl/l2_bank_init_scrubber.sv
// L2 bank front-end: zero-fills the bank after reset/init request, then passes host traffic through.
// Background scrub reads are compiled in only when L2_BANK_SCRUB_EN is defined.
module l2_bank_init_scrubber #(
  parameter int unsigned BANK_SIZE      = 32768,
  parameter int unsigned SCRUB_INTERVAL = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_ni,
  input  logic        host_req_i,
  input  logic        host_wen_i,
  input  logic [31:0] host_add_i,
  input  logic [31:0] host_wdata_i,
  input  logic [3:0]  host_be_i,
  output logic        host_gnt_o,
  output logic        host_r_valid_o,
  output logic [31:0] host_r_rdata_o,
  output logic        bank_req_o,
  output logic        bank_wen_o,
  output logic [31:0] bank_add_o,
  output logic [31:0] bank_wdata_o,
  output logic [3:0]  bank_be_o,
  input  logic        bank_gnt_i,
  input  logic [31:0] bank_rdata_i,
  output logic        init_done_o,
  output logic [15:0] scrub_pass_o
);

  localparam int unsigned AW = $clog2(BANK_SIZE);
  localparam logic [AW-1:0] LastWord = {AW{1'b1}};

  typedef enum logic [1:0] {StInitHold, StInitWalk, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          rvalid_q;
  logic          scrub_sel;
  logic [AW-1:0] scrub_addr;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = done_q;
    bank_req_o   = 1'b0;
    bank_wen_o   = host_wen_i;
    bank_add_o   = host_add_i;
    bank_wdata_o = host_wdata_i;
    bank_be_o    = host_be_i;
    host_gnt_o   = 1'b0;

    unique case (state_q)
      StInitHold: begin
        cnt_d   = '0;
        done_d  = 1'b0;
        state_d = StInitWalk;
      end
      StInitWalk: begin
        bank_req_o   = 1'b1;
        bank_wen_o   = 1'b0;
        bank_add_o   = 32'({cnt_q, 2'b00});
        bank_wdata_o = '0;
        bank_be_o    = 4'hF;
        if (bank_gnt_i) begin
          if (cnt_q == LastWord) begin
            state_d = StRun;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (host_req_i) begin
          bank_req_o = 1'b1;
          host_gnt_o = bank_gnt_i;
        end else if (scrub_sel) begin
          bank_req_o   = 1'b1;
          bank_wen_o   = 1'b1;
          bank_add_o   = 32'({scrub_addr, 2'b00});
          bank_wdata_o = '0;
          bank_be_o    = 4'hF;
        end
      end
      default: state_d = StInitHold;
    endcase

    // Init request overrides everything, including the current cycle's bank access.
    if (!init_ni) begin
      state_d    = StInitHold;
      cnt_d      = '0;
      done_d     = 1'b0;
      bank_req_o = 1'b0;
      host_gnt_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StInitHold;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      rvalid_q <= host_req_i & host_gnt_o;
    end
  end

  assign init_done_o    = done_q;
  assign host_r_valid_o = rvalid_q;
  assign host_r_rdata_o = bank_rdata_i;

`ifdef L2_BANK_SCRUB_EN
  localparam int unsigned IW = $clog2(SCRUB_INTERVAL);
  localparam logic [IW-1:0] IntvLast = IW'(SCRUB_INTERVAL - 1);

  logic          pend_q, pend_d;
  logic [IW-1:0] intv_q, intv_d;
  logic [AW-1:0] saddr_q, saddr_d;
  logic [15:0]   pass_q, pass_d;
  logic          scrub_gnt;

  assign scrub_sel  = pend_q && (state_q == StRun);
  assign scrub_addr = saddr_q;
  assign scrub_gnt  = scrub_sel && !host_req_i && init_ni && bank_gnt_i;

  always_comb begin
    pend_d  = pend_q;
    intv_d  = intv_q;
    saddr_d = saddr_q;
    pass_d  = pass_q;
    if ((state_q != StRun) || !init_ni) begin
      pend_d = 1'b0;
      intv_d = '0;
    end else if (!pend_q) begin
      if (intv_q == IntvLast) begin
        pend_d = 1'b1;
        intv_d = '0;
      end else begin
        intv_d = intv_q + 1'b1;
      end
    end else if (scrub_gnt) begin
      pend_d  = 1'b0;
      saddr_d = saddr_q + 1'b1;
      if ((saddr_q == LastWord) && (pass_q != 16'hFFFF)) begin
        pass_d = pass_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= 1'b0;
      intv_q  <= '0;
      saddr_q <= '0;
      pass_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      intv_q  <= intv_d;
      saddr_q <= saddr_d;
      pass_q  <= pass_d;
    end
  end

  assign scrub_pass_o = pass_q;
`else
  assign scrub_sel    = 1'b0;
  assign scrub_addr   = '0;
  assign scrub_pass_o = 16'h0;
`endif

endmodule

// File: tb/tb_l2_bank_init_scrubber.sv
// Scoreboard bench for l2_bank_init_scrubber (BANK_SIZE=16, SCRUB_INTERVAL=8).
// Scrub checks are active when L2_BANK_SCRUB_EN is defined; otherwise any scrub access is a failure.
`timescale 1ns/1ps
module tb_l2_bank_init_scrubber;

  localparam int unsigned BankSize = 16;
  localparam int unsigned Interval = 8;

  logic        clk, rst_n, init_n;
  logic        host_req, host_wen;
  logic [31:0] host_add, host_wdata;
  logic [3:0]  host_be;
  logic        host_gnt, rvalid;
  logic [31:0] rdata;
  logic        bank_req, bank_wen;
  logic [31:0] bank_add, bank_wdata;
  logic [3:0]  bank_be;
  logic        bank_gnt;
  logic [31:0] bank_rdata;
  logic        init_done;
  logic [15:0] scrub_pass;

  typedef struct packed {
    logic        wen;
    logic [31:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bank_t;

  bank_t       bank_q[$];
  logic [31:0] rsp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          scrub_idx = 0;

  l2_bank_init_scrubber #(
    .BANK_SIZE     (BankSize),
    .SCRUB_INTERVAL(Interval)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .init_ni       (init_n),
    .host_req_i    (host_req),
    .host_wen_i    (host_wen),
    .host_add_i    (host_add),
    .host_wdata_i  (host_wdata),
    .host_be_i     (host_be),
    .host_gnt_o    (host_gnt),
    .host_r_valid_o(rvalid),
    .host_r_rdata_o(rdata),
    .bank_req_o    (bank_req),
    .bank_wen_o    (bank_wen),
    .bank_add_o    (bank_add),
    .bank_wdata_o  (bank_wdata),
    .bank_be_o     (bank_be),
    .bank_gnt_i    (bank_gnt),
    .bank_rdata_i  (bank_rdata),
    .init_done_o   (init_done),
    .scrub_pass_o  (scrub_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_bank(input logic wen, input logic [31:0] add, input logic [31:0] wdata,
                           input logic [3:0] be);
    bank_t e;
    e.wen   = wen;
    e.add   = add;
    e.wdata = wdata;
    e.be    = be;
    bank_q.push_back(e);
  endtask

  // Monitor: granted bank accesses and read responses are popped and compared.
  always @(negedge clk) begin : mon
    bank_t e;
    if (rst_n && bank_req && bank_gnt) begin
      if (init_done && !host_req) begin
`ifdef L2_BANK_SCRUB_EN
        chk("scrub_wen", {31'b0, bank_wen}, 32'd1);
        chk("scrub_be", {28'b0, bank_be}, 32'hF);
        chk("scrub_add", bank_add, 32'(scrub_idx * 4));
        scrub_idx = (scrub_idx + 1) % BankSize;
`else
        chk("no_scrub_access", {31'b0, bank_req}, 32'd0);
`endif
      end else if (bank_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bank_unexpected: got access at 0x%08h expected none", bank_add);
      end else begin
        e = bank_q.pop_front();
        chk("bank_wen", {31'b0, bank_wen}, {31'b0, e.wen});
        chk("bank_add", bank_add, e.add);
        chk("bank_wdata", bank_wdata, e.wdata);
        chk("bank_be", {28'b0, bank_be}, {28'b0, e.be});
      end
    end
    if (rst_n && rvalid) begin
      if (rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got r_valid data 0x%08h expected none", rdata);
      end else begin
        chk("rsp_rdata", rdata, rsp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic [31:0] prev_add;
    logic        prev_stall;

    rst_n = 1'b0; init_n = 1'b1; host_req = 1'b1; host_wen = 1'b1; host_add = '0;
    host_wdata = '0; host_be = 4'hF; bank_gnt = 1'b1; bank_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_init_done", {31'b0, init_done}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_scrub_pass", {16'b0, scrub_pass}, 32'd0);
    chk("rst_bank_req", {31'b0, bank_req}, 32'd0);
    chk("rst_host_gnt", {31'b0, host_gnt}, 32'd0);

    // Initial walk: 16 zero writes on consecutive cycles.
    for (int i = 0; i < 16; i++) push_bank(1'b0, 32'(i * 4), 32'h0, 4'hF);
    host_req = 1'b0;
    rst_n    = 1'b1;
    n = 0;
    while (!init_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("init_done_cycle", 32'(n), 32'd17);

    // Host read then write in RUN.
    bank_rdata = 32'hDEADBEEF;
    host_req = 1'b1; host_wen = 1'b1; host_add = 32'h20; host_wdata = '0; host_be = 4'hF;
    push_bank(1'b1, 32'h20, 32'h0, 4'hF);
    rsp_q.push_back(32'hDEADBEEF);
    #1;
    chk("host_gnt_read", {31'b0, host_gnt}, 32'd1);
    @(posedge clk); #1;
    chk("rvalid_read", {31'b0, rvalid}, 32'd1);
    chk("rdata_read", rdata, 32'hDEADBEEF);
    host_wen = 1'b0; host_add = 32'h10; host_wdata = 32'h12345678; host_be = 4'h3;
    push_bank(1'b0, 32'h10, 32'h12345678, 4'h3);
    rsp_q.push_back(32'hDEADBEEF);
    @(posedge clk); #1;
    host_req = 1'b0; host_wdata = '0; host_be = 4'hF;
    #1;

`ifdef L2_BANK_SCRUB_EN
    // First scrub lands in RUN cycle 8.
    for (int k = 2; k <= 8; k++) begin
      chk("scrub_start", {31'b0, bank_req}, {31'b0, k == 8});
      if (k < 8) begin
        @(posedge clk); #1;
      end
    end
    n = 0;
    while (scrub_pass != 16'd1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scrub_pass_one", {16'b0, scrub_pass}, 32'd1);
    chk("scrub_count_wrapped", 32'(scrub_idx), 32'd0);
    repeat (8) begin
      @(posedge clk); #1;
    end
`else
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("scrub_pass_tied", {16'b0, scrub_pass}, 32'd0);
`endif

    // Host burst of 5 reads; any pending scrub must wait for it.
    for (int i = 0; i < 5; i++) begin
      host_req = 1'b1; host_wen = 1'b1; host_add = 32'(32'h30 + 4 * i);
      bank_rdata = 32'(32'hC0DE0000 + i);
      push_bank(1'b1, 32'(32'h30 + 4 * i), 32'h0, 4'hF);
      rsp_q.push_back(32'(32'hC0DE0000 + i + 1));
      #1;
      chk("burst_gnt", {31'b0, host_gnt}, 32'd1);
      @(posedge clk); #1;
    end
    host_req = 1'b0; bank_rdata = 32'hC0DE0005;
    #1;
`ifdef L2_BANK_SCRUB_EN
    chk("deferred_scrub_req", {31'b0, bank_req}, 32'd1);
    chk("deferred_scrub_wen", {31'b0, bank_wen}, 32'd1);
    chk("deferred_scrub_add", bank_add, 32'h0);
`else
    chk("no_deferred_scrub", {31'b0, bank_req}, 32'd0);
`endif

    // Init pulse for 3 cycles with a host request pending.
    @(posedge clk); #1;
    init_n = 1'b0; host_req = 1'b1; host_add = 32'h40;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("pulse_bank_req", {31'b0, bank_req}, 32'd0);
      chk("pulse_host_gnt", {31'b0, host_gnt}, 32'd0);
      if (i > 0) chk("pulse_init_done", {31'b0, init_done}, 32'd0);
      @(posedge clk); #1;
    end
    init_n = 1'b1; host_req = 1'b0;

    // Re-walk with a toggling bank grant: stalled addresses must be held.
    for (int i = 0; i < 16; i++) push_bank(1'b0, 32'(i * 4), 32'h0, 4'hF);
    n = 0;
    prev_stall = 1'b0;
    prev_add   = '0;
    while (!init_done && n < 200) begin
      bank_gnt = (n % 2 == 0);
      #1;
      if (prev_stall && bank_req) chk("walk_hold", bank_add, prev_add);
      prev_stall = bank_req && !bank_gnt;
      prev_add   = bank_add;
      @(posedge clk); #1;
      n++;
    end
    chk("reinit_done", {31'b0, init_done}, 32'd1);
    bank_gnt = 1'b1;

    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("bank_q_drained", 32'(bank_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_bank_init_scrubber.md
L2_BANK_INIT_SCRUBBER -- requirements
Module: l2_bank_init_scrubber

Interface
REQ-001 SHALL have parameter BANK_SIZE, default 32768, bank depth in 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter SCRUB_INTERVAL, default 1024, idle cycles between scrub reads (>=2).
REQ-003 SHALL have port clk_i, input, 1, clock.
REQ-004 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port init_ni, input, 1, active-low re-initialisation request.
REQ-006 SHALL have host ports host_req_i (in, 1), host_wen_i (in, 1; 1=read, 0=write), host_add_i (in, 32; byte address, offset removed), host_wdata_i (in, 32), host_be_i (in, 4).
REQ-007 SHALL have host response ports host_gnt_o (out, 1), host_r_valid_o (out, 1), host_r_rdata_o (out, 32).
REQ-008 SHALL have bank ports bank_req_o (out, 1), bank_wen_o (out, 1), bank_add_o (out, 32; byte address), bank_wdata_o (out, 32), bank_be_o (out, 4), bank_gnt_i (in, 1), bank_rdata_i (in, 32).
REQ-009 SHALL have status ports init_done_o (out, 1) and scrub_pass_o (out, 16; completed full scrub passes).

Function
REQ-010 SHALL implement FSM states INIT_HOLD, INIT_WALK, RUN.
REQ-011 INIT_HOLD: bank_req_o=0, host_gnt_o=0, word counter=0; leave to INIT_WALK on the first cycle init_ni=1.
REQ-012 INIT_WALK: bank_req_o=1, bank_wen_o=0, bank_be_o=4'hF, bank_wdata_o=0, bank_add_o=counter*4; counter increments only on bank_gnt_i.
REQ-013 Grant in INIT_WALK at counter BANK_SIZE-1 -> RUN next cycle, counter=0, init_done_o=1 registered.
REQ-014 In any state, init_ni=0 -> INIT_HOLD next cycle, init_done_o=0, scrub pending cleared; the interrupted host transaction gets no r_valid.
REQ-015 host_gnt_o SHALL be 0 outside RUN; host requests are held off, never dropped.
REQ-016 RUN, host_req_i=1: bank_* SHALL be combinational pass-through of host_*; host_gnt_o=bank_gnt_i.
REQ-017 host_r_valid_o SHALL be registered host_req_i&host_gnt_o (1-cycle latency); host_r_rdata_o=bank_rdata_i combinationally.
REQ-018 Interval counter counts RUN cycles with no scrub pending; at SCRUB_INTERVAL-1 sets scrub pending and resets.
REQ-019 Scrub pending and host_req_i=0: bank_req_o=1, bank_wen_o=1, bank_be_o=4'hF, bank_add_o=scrub_addr*4.
REQ-020 Host always has priority; a pending scrub coinciding with host_req_i=1 is deferred, not lost.
REQ-021 Scrub grant clears pending; scrub_addr wraps BANK_SIZE-1 -> 0; each wrap increments scrub_pass_o, saturating at 16'hFFFF.
REQ-022 Scrub read data SHALL never assert host_r_valid_o.
REQ-023 Width rule: counters sized $clog2(BANK_SIZE); upper bank_add_o bits zero in generated accesses.

Reset
REQ-024 Reset SHALL give state INIT_HOLD, all counters 0, pending 0, init_done_o=0, host_r_valid_o=0, scrub_pass_o=0.
REQ-025 With init_ni=1 at reset release, INIT_WALK SHALL begin on the first clock edge.
REQ-026 Reset mid-walk SHALL abandon the walk; it restarts at word 0.

Configuration
REQ-027 Macro L2_BANK_SCRUB_EN SHALL compile in REQ-018..REQ-022.
REQ-028 Without L2_BANK_SCRUB_EN: RUN is pure pass-through, no scrub reads, scrub_pass_o tied to 0; init behaviour unchanged.

Verification (BANK_SIZE=16, SCRUB_INTERVAL=8, bank grants every request unless stated)
REQ-029 Reset release, init_ni=1 -> 16 zero writes to 0x00..0x3C on consecutive cycles; init_done_o=1 in cycle 17.
REQ-030 Bank gnt toggling 0/1 during walk -> address 0x08 held until granted; 16 writes total, none skipped or repeated.
REQ-031 RUN, host read 0x20, bank_rdata_i=0xDEADBEEF -> host_gnt_o=1 same cycle; host_r_valid_o=1, host_r_rdata_o=0xDEADBEEF next cycle.
REQ-032 RUN idle, L2_BANK_SCRUB_EN defined -> scrub read 0x00 after 8 cycles, then 0x04; after 16 scrubs scrub_pass_o=1; host_r_valid_o stays 0.
REQ-033 Scrub pending with host_req_i=1 for 5 cycles -> 5 host grants, scrub issued the cycle host_req_i falls.
REQ-034 init_ni pulsed low for 3 cycles in RUN -> init_done_o=0, bank_req_o=0 while low, full 16-word walk restarts at 0x00.
